// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix result path.
package matrix_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StLenHi,
    StLenLo,
    StRdReq,
    StRdWait,
    StDataHi,
    StDataLo,
    StCsum,
    StDone
  } streamer_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned BYTES_PER_WORD    = 2;

endpackage

// File: rtl/matrix_result_streamer.sv
// Streams result words from BRAM to the UART as a framed byte stream:
// sync byte, 16-bit word count, words MSB-first, XOR checksum.
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0]       MaxCount = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CntW-1:0]       CntOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  streamer_state_t r_state;
  logic [CntW-1:0] r_remain;
  logic [7:0]      r_word_lo;
  logic [7:0]      r_csum;

  logic            w_hs;
  logic [7:0]      w_csum_next;
  logic [15:0]     w_len;
  logic [CntW-1:0] w_count_sat;

  assign w_hs        = tx_valid && tx_ready;
  assign w_csum_next = r_csum ^ tx_data;
  assign w_len       = {{(16-CntW){1'b0}}, r_remain};
  assign w_count_sat = (count > MaxCount) ? MaxCount : count;

  // mem_addr doubles as the address counter; r_remain is also the header length
  // until the first word is sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_remain    <= '0;
      r_word_lo   <= '0;
      r_csum      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_read_en <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      done        <= 1'b0;
      mem_read_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            mem_addr <= base_addr;
            r_remain <= w_count_sat;
            r_csum   <= '0;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_BYTE;
            r_state  <= StHdr;
          end
        end
        StHdr: begin
          if (w_hs) begin
            tx_data <= w_len[15:8];
            r_state <= StLenHi;
          end
        end
        StLenHi: begin
          if (w_hs) begin
            r_csum  <= w_csum_next;
            tx_data <= w_len[7:0];
            r_state <= StLenLo;
          end
        end
        StLenLo: begin
          if (w_hs) begin
            r_csum <= w_csum_next;
            if (r_remain == '0) begin
              tx_data <= w_csum_next;
              r_state <= StCsum;
            end else begin
              tx_valid    <= 1'b0;
              mem_read_en <= 1'b1;
              r_state     <= StRdReq;
            end
          end
        end
        StRdReq: r_state <= StRdWait;
        StRdWait: begin
          r_word_lo <= mem_data[7:0];
          tx_data   <= mem_data[15:8];
          tx_valid  <= 1'b1;
          r_state   <= StDataHi;
        end
        StDataHi: begin
          if (w_hs) begin
            r_csum  <= w_csum_next;
            tx_data <= r_word_lo;
            r_state <= StDataLo;
          end
        end
        StDataLo: begin
          if (w_hs) begin
            r_csum   <= w_csum_next;
            mem_addr <= mem_addr + AddrOne;
            r_remain <= r_remain - CntOne;
            if (r_remain == CntOne) begin
              tx_data <= w_csum_next;
              r_state <= StCsum;
            end else begin
              tx_valid    <= 1'b0;
              mem_read_en <= 1'b1;
              r_state     <= StRdReq;
            end
          end
        end
        StCsum: begin
          if (w_hs) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Randomized bench for matrix_result_streamer against a frame-level reference model.
module tb_matrix_result_streamer;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] count = '0;
  logic        busy, done, mem_read_en, tx_valid;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data = '0;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;

  matrix_result_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_read_en(mem_read_en),
    .mem_data   (mem_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  always @(posedge clk) if (mem_read_en) mem_data <= mem[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  logic [7:0] rx_q[$];
  int         rd_q[$];
  int         done_cnt, stall_bad, rd_bad, stall_cycles;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int         ready_mode = 0;
  int         stall_left = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_bad++;
      if (mem_read_en && tx_valid) rd_bad++;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_valid && !tx_ready) stall_cycles++;
      if (mem_read_en) rd_q.push_back(int'(mem_addr));
      if (done) done_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // tx_ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall on first data byte
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (rx_q.size() == 3 && tx_valid && stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
        end else begin
          tx_ready = 1'b1;
        end
      end
      default: tx_ready = 1'b1;
    endcase
  end

  // Reference model: expected frame bytes and read addresses
  logic [7:0] exp_b[$];
  int         exp_a[$];
  int         exp_words;

  task automatic build_expected(input int base, input int cnt);
    logic [15:0] n16;
    logic [15:0] w;
    logic [7:0]  cs;
    int          a;
    exp_words = (cnt > 1024) ? 1024 : cnt;
    n16 = 16'(exp_words);
    exp_b.delete();
    exp_a.delete();
    exp_b.push_back(8'hA5);
    exp_b.push_back(n16[15:8]);
    exp_b.push_back(n16[7:0]);
    cs = n16[15:8] ^ n16[7:0];
    for (int i = 0; i < exp_words; i++) begin
      a = (base + i) % 1024;
      exp_a.push_back(a);
      w = mem[a];
      exp_b.push_back(w[15:8]);
      exp_b.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    exp_b.push_back(cs);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
  endtask

  task automatic clear_mon(input int mode);
    rx_q.delete();
    rd_q.delete();
    done_cnt     = 0;
    stall_bad    = 0;
    rd_bad       = 0;
    stall_cycles = 0;
    stall_left   = 5;
    ready_mode   = mode;
  endtask

  task automatic pulse_start(input int base, input int cnt);
    @(posedge clk);
    #1;
    base_addr = 10'(base);
    count     = 11'(cnt);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input int base, input int cnt, input int mode,
                           input bit extra_start);
    int c;
    build_expected(base, cnt);
    clear_mon(mode);
    pulse_start(base, cnt);
    check({name, "_busy1"}, busy, 1);
    check({name, "_valid1"}, tx_valid, 1);
    check({name, "_sync1"}, tx_data, 8'hA5);
    if (extra_start) begin
      repeat (4) @(posedge clk);
      pulse_start((base + 100) % 1024, cnt + 3);
    end
    c = 0;
    while (done_cnt == 0 && c < 40000) begin
      @(posedge clk);
      c++;
    end
    check({name, "_done_seen"}, done_cnt != 0, 1);
    repeat (20) @(posedge clk);
    #1;
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_len"}, rx_q.size(), 4 + BYTES_PER_WORD * exp_words);
    for (int i = 0; i < exp_b.size(); i++)
      check($sformatf("%s_byte%0d", name, i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF,
            32'(exp_b[i]));
    check({name, "_nreads"}, rd_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      check($sformatf("%s_raddr%0d", name, i), (i < rd_q.size()) ? rd_q[i] : -1, exp_a[i]);
    check({name, "_hold"}, stall_bad, 0);
    check({name, "_rd_pending"}, rd_bad, 0);
    ready_mode = 0;
  endtask

  initial begin
    int c;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_rden", mem_read_en, 0);
    check("reset_txd", tx_data, 0);
    check("reset_txv", tx_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    fill_mem();
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    run_frame("basic", 0, 2, 0, 0);
    check("basic_csum", rx_q[rx_q.size() - 1], 8'h42);

    run_frame("empty", 7, 0, 0, 0);
    fill_mem();
    run_frame("wrap", 10'h3FF, 2, 1, 0);
    run_frame("sat", 5, 11'h7FF, 0, 0);
    fill_mem();
    run_frame("bp", 33, 3, 2, 0);
    check("bp_stall_cycles", stall_cycles, 5);
    run_frame("busy_start", 50, 3, 1, 1);

    // Reset in the middle of a DATA_LO byte
    fill_mem();
    clear_mon(0);
    pulse_start(16, 4);
    c = 0;
    while (rx_q.size() < 4 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("rstmid_reached", rx_q.size(), 4);
    @(posedge clk);
    #2;
    check("rstmid_pre_valid", tx_valid, 1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_rden", mem_read_en, 0);
    check("rstmid_txd", tx_data, 0);
    check("rstmid_txv", tx_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame("after_rst", 16, 4, 0, 0);

    for (int k = 0; k < 3; k++) begin
      fill_mem();
      run_frame($sformatf("rand%0d", k), int'($urandom_range(0, 1023)),
                int'($urandom_range(1, 40)), 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
